// File: rtl/px_cycle_seq.sv
// P-X strobe/timing sequencer: counter-timed STROB1/STROB2/GOT cycle with a bus
// request/OK handshake, retry and no-answer alarm across NCH system-bus interfaces.
module px_cycle_seq #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CW          = 8,
  parameter int unsigned S1_TICKS    = 5,
  parameter int unsigned S1L_TICKS   = 6,
  parameter int unsigned S2_TICKS    = 6,
  parameter int unsigned GOT_TICKS   = 5,
  parameter int unsigned ALARM_TICKS = 250
) (
  input  logic           __clk,
  input  logic           clo,
  input  logic           mode,
  input  logic           step,
  input  logic           stop,
  input  logic           st_long,
  input  logic           two_strob,
  input  logic           bus_need,
  input  logic [NCH-1:0] ch_sel,
  input  logic [NCH-1:0] zw,
  input  logic [NCH-1:0] ok,
  input  logic [NCH-1:0] en,
  output logic           strob1,
  output logic           strob2,
  output logic           got,
  output logic           got_ce,
  output logic [NCH-1:0] zg,
  output logic           alarm,
  output logic           awaria,
  output logic           halted,
  output logic [2:0]     seq_st
);

  typedef enum logic [2:0] {
    ST_GATE = 3'd0,
    ST_S1   = 3'd1,
    ST_BUS  = 3'd2,
    ST_S2   = 3'd3,
    ST_GOT  = 3'd4,
    ST_RTRY = 3'd5
  } state_t;

  localparam logic [CW-1:0] S1_LAST    = CW'(S1_TICKS - 1);
  localparam logic [CW-1:0] S1L_LAST   = CW'(S1L_TICKS - 1);
  localparam logic [CW-1:0] S2_LAST    = CW'(S2_TICKS - 1);
  localparam logic [CW-1:0] GOT_LAST   = CW'(GOT_TICKS - 1);
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_TICKS - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           long_q, long_d;
  logic           two_q, two_d;
  logic [NCH-1:0] ch_q, ch_d;
  logic [2:0]     step_sync_q, step_sync_d;
  logic           awaria_q, awaria_d;

  logic           step_edge;
  logic [NCH-1:0] ch_low;
  logic [NCH-1:0] resp_v;
  logic           ok_v, en_v;
  logic           halt_c;
  state_t         after_s1;

  always_comb begin
    // [0],[1] synchroniser, [2] previous synchronised level for edge detect
    step_sync_d = {step_sync_q[1:0], step};
    step_edge   = step_sync_q[1] & ~step_sync_q[2];
    ch_low      = ch_sel & (~ch_sel + NCH'(1));
    resp_v      = zw & ch_q;
    ok_v        = |(resp_v & ok);
    en_v        = |(resp_v & en);
    after_s1    = two_strob ? ST_S2 : ST_GOT;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    long_d   = long_q;
    two_d    = two_q;
    ch_d     = ch_q;
    awaria_d = awaria_q;
    strob1   = 1'b0;
    strob2   = 1'b0;
    got      = 1'b0;
    got_ce   = 1'b0;
    zg       = '0;
    alarm    = 1'b0;
    halt_c   = 1'b0;

    unique case (state_q)
      ST_GATE: begin
        if (stop || (mode && !step_edge)) begin
          halt_c = 1'b1;
        end else begin
          state_d = ST_S1;
          cnt_d   = '0;
          long_d  = st_long;
        end
      end
      ST_S1: begin
        strob1 = 1'b1;
        if (cnt_q == (long_q ? S1L_LAST : S1_LAST)) begin
          cnt_d = '0;
          two_d = two_strob;
          ch_d  = ch_low;
          if (bus_need && (ch_sel != '0)) state_d = ST_BUS;
          else                            state_d = after_s1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BUS: begin
        zg = ch_q;
        // ok wins over en; timeout completes the cycle as if answered
        if (ok_v) begin
          cnt_d   = '0;
          state_d = two_q ? ST_S2 : ST_GOT;
        end else if (en_v) begin
          cnt_d   = '0;
          state_d = ST_RTRY;
        end else if (cnt_q == ALARM_LAST) begin
          alarm    = 1'b1;
          awaria_d = 1'b1;
          cnt_d    = '0;
          state_d  = two_q ? ST_S2 : ST_GOT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RTRY: begin
        cnt_d   = '0;
        state_d = ST_BUS;
      end
      ST_S2: begin
        strob2 = 1'b1;
        if (cnt_q == S2_LAST) begin
          cnt_d   = '0;
          state_d = ST_GOT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GOT: begin
        got    = 1'b1;
        got_ce = (cnt_q == '0);
        if (cnt_q == GOT_LAST) begin
          cnt_d   = '0;
          state_d = ST_GATE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_GATE;
      end
    endcase
  end

  always_ff @(posedge __clk or posedge clo) begin
    if (clo) begin
      state_q     <= ST_GATE;
      cnt_q       <= '0;
      long_q      <= 1'b0;
      two_q       <= 1'b0;
      ch_q        <= '0;
      step_sync_q <= '0;
      awaria_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_q      <= long_d;
      two_q       <= two_d;
      ch_q        <= ch_d;
      step_sync_q <= step_sync_d;
      awaria_q    <= awaria_d;
    end
  end

  // halted is input-dependent in GATE, so it is masked while clear is held
  assign halted = halt_c & ~clo;
  assign awaria = awaria_q;
  assign seq_st = state_q;

endmodule

// File: tb/tb_px_cycle_seq.sv
// Bench for px_cycle_seq: random single-stepped cycles scored against expected
// cycle profiles, plus directed free-run, stop, step and clear scenarios.
module tb_px_cycle_seq;
  localparam int NCH   = 2;
  localparam int ALARM = 250;

  logic clk = 1'b0;
  logic clo = 1'b1, mode = 1'b1, step = 1'b0, stop = 1'b0;
  logic st_long = 1'b0, two_strob = 1'b0, bus_need = 1'b0;
  logic [NCH-1:0] ch_sel = '0, zw = '0, ok = '0, en = '0;
  logic strob1, strob2, got, got_ce, alarm, awaria, halted;
  logic [NCH-1:0] zg;
  logic [2:0] seq_st;

  int n_vec = 0, n_err = 0;

  typedef struct {
    int s1; int s2; int gt; int zgc; int gaps; int al;
    logic [NCH-1:0] zgv; logic aw;
  } exp_t;

  exp_t sb[$];
  logic aw_model = 1'b0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  px_cycle_seq #(
    .NCH(NCH), .CW(8), .S1_TICKS(5), .S1L_TICKS(6), .S2_TICKS(6),
    .GOT_TICKS(5), .ALARM_TICKS(ALARM)
  ) dut (
    .__clk(clk), .clo(clo), .mode(mode), .step(step), .stop(stop),
    .st_long(st_long), .two_strob(two_strob), .bus_need(bus_need),
    .ch_sel(ch_sel), .zw(zw), .ok(ok), .en(en),
    .strob1(strob1), .strob2(strob2), .got(got), .got_ce(got_ce),
    .zg(zg), .alarm(alarm), .awaria(awaria), .halted(halted), .seq_st(seq_st)
  );

  task automatic check(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: profiles each cycle from strob1 rise back to idle, then scores it
  logic in_cyc = 1'b0;
  int m_s1, m_s2, m_g, m_ce, m_zg, m_gap, m_al, m_ovl;
  logic [NCH-1:0] m_zgv;

  always @(negedge clk) begin
    int act;
    exp_t e;
    if (clo || !mon_en) begin
      in_cyc = 1'b0;
    end else begin
      if (!in_cyc && strob1) begin
        in_cyc = 1'b1;
        m_s1 = 0; m_s2 = 0; m_g = 0; m_ce = 0; m_zg = 0; m_gap = 0; m_al = 0; m_ovl = 0;
        m_zgv = '0;
      end
      if (in_cyc) begin
        act = int'(strob1) + int'(strob2) + int'(got) + int'(zg != '0);
        if (act == 0) begin
          if (m_g > 0) begin
            in_cyc = 1'b0;
            if (sb.size() == 0) begin
              check("sb_underflow", 0, 1);
            end else begin
              e = sb.pop_front();
              check("s1_len", m_s1, e.s1);
              check("s2_len", m_s2, e.s2);
              check("got_len", m_g, e.gt);
              check("got_ce_cnt", m_ce, 1);
              check("zg_cycles", m_zg, e.zgc);
              check("zg_chan", int'(m_zgv), int'(e.zgv));
              check("retry_gaps", m_gap, e.gaps);
              check("alarm_cnt", m_al, e.al);
              check("overlap", m_ovl, 0);
              check("awaria", int'(awaria), int'(e.aw));
            end
          end else begin
            m_gap++;
          end
        end else begin
          m_s1 += int'(strob1);
          m_s2 += int'(strob2);
          m_g  += int'(got);
          m_ce += int'(got_ce & got);
          m_zg += int'(zg != '0);
          m_al += int'(alarm);
          m_zgv = m_zgv | zg;
          if (act > 1) m_ovl++;
        end
      end
    end
  end

  // kind: 0..5 ok after d1 (5 = ok+en together), 6..8 en retry then ok, 9 no answer
  task automatic run_txn(input int fk);
    exp_t e;
    int kind, d1, d2, ch, oth, n, ph;
    logic lng, two, bn, noise, busy, done, gseen;
    logic [NCH-1:0] cs;
    lng   = 1'($urandom_range(0, 1));
    two   = 1'($urandom_range(0, 1));
    bn    = ($urandom_range(0, 3) != 0);
    noise = 1'($urandom_range(0, 1));
    cs    = NCH'($urandom_range(0, (1 << NCH) - 1));
    kind  = (fk >= 0) ? fk : int'($urandom_range(0, 9));
    d1    = int'($urandom_range(1, 6));
    d2    = int'($urandom_range(1, 6));
    if (fk >= 0) begin
      bn = 1'b1;
      if (cs == '0) cs = NCH'(2);
    end
    busy = bn && (cs != '0);
    ch = 0;
    for (int i = NCH - 1; i >= 0; i--) if (cs[i]) ch = i;
    oth = 1 - ch;

    e.s1 = lng ? 6 : 5;
    e.s2 = two ? 6 : 0;
    e.gt = 5;
    e.zgc = 0; e.gaps = 0; e.al = 0; e.zgv = '0;
    if (busy) begin
      e.zgv[ch] = 1'b1;
      if (kind <= 5) e.zgc = d1;
      else if (kind <= 8) begin e.zgc = d1 + d2; e.gaps = 1; end
      else begin e.zgc = ALARM; e.al = 1; aw_model = 1'b1; end
    end
    e.aw = aw_model;
    sb.push_back(e);

    st_long = lng; two_strob = two; bus_need = bn; ch_sel = cs;
    n = 0; ph = 0; done = 1'b0; gseen = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      tick();
      step = (t < 3);
      zw = '0; ok = '0; en = '0;
      if (got) gseen = 1'b1;
      if (gseen && !got) begin
        done = 1'b1;
      end else if (busy && zg[ch]) begin
        n++;
        if (kind <= 8 && ((ph == 0 && n == d1) || (ph == 1 && n == d2))) begin
          zw[ch] = 1'b1;
          if (kind >= 6 && ph == 0) begin
            en[ch] = 1'b1; ph = 1; n = 0;
          end else begin
            ok[ch] = 1'b1;
            if (kind == 5) en[ch] = 1'b1;
          end
        end else if (noise) begin
          ok[ch] = 1'b1;
          zw[oth] = 1'b1; ok[oth] = 1'b1; en[oth] = 1'b1;
        end
      end
    end
    step = 1'b0;
    if (!done) check("txn_timeout", 0, 1);
  endtask

  task automatic measure(input string nm, input int ep, input int es1, input int es2);
    int p, s1, s2, g, ce;
    logic prev, f1, f2;
    f1 = 1'b0; f2 = 1'b0; prev = strob1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (strob1 && !prev) begin f1 = 1'b1; break; end
      prev = strob1;
    end
    p = 1; s1 = 1; s2 = 0; g = 0; ce = 0; prev = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (strob1 && !prev) begin f2 = 1'b1; break; end
      p++;
      s1 += int'(strob1); s2 += int'(strob2); g += int'(got); ce += int'(got_ce);
      prev = strob1;
    end
    check({nm, "_sync"}, int'(f1 && f2), 1);
    check({nm, "_period"}, p, ep);
    check({nm, "_s1"}, s1, es1);
    check({nm, "_s2"}, s2, es2);
    check({nm, "_got"}, g, 5);
    check({nm, "_got_ce"}, ce, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c2, cg;
    logic found, prev, done;

    repeat (3) @(negedge clk);
    #1;
    check("rst_outs", int'({strob1, strob2, got, got_ce, zg, alarm, awaria, halted}), 0);
    check("rst_seq_st", int'(seq_st), 0);
    clo = 1'b0;
    aw_model = 1'b0;
    tick();
    check("mode_halted", int'(halted), 1);
    s = 0;
    repeat (10) begin tick(); s += int'(strob1); end
    check("mode_no_s1", s, 0);

    mon_en = 1'b1;
    run_txn(0);
    run_txn(6);
    run_txn(9);
    repeat (40) run_txn(-1);
    tick();
    mon_en = 1'b0;
    check("awaria_sticky", int'(awaria), 1);

    clo = 1'b1;
    #1;
    check("clo_clears_awaria", int'(awaria), 0);
    tick();
    clo = 1'b0;
    aw_model = 1'b0;

    // clear in the middle of a bus transfer
    bus_need = 1'b1; ch_sel = NCH'(1); st_long = 1'b0; two_strob = 1'b0;
    step = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (t == 3) step = 1'b0;
      if (zg != '0) begin found = 1'b1; break; end
    end
    step = 1'b0;
    check("bus_reached", int'(found), 1);
    check("bus_zg_chan", int'(zg), 1);
    repeat (2) tick();
    clo = 1'b1;
    #1;
    check("clo_zg_drop", int'(zg), 0);
    check("clo_state", int'(seq_st), 0);
    tick();
    clo = 1'b0; bus_need = 1'b0;
    tick();
    check("post_clo_halted", int'(halted), 1);
    check("post_clo_awaria", int'(awaria), 0);

    // free-running cycle lengths
    tick();
    mode = 1'b0;
    measure("short", 11, 5, 0);
    st_long = 1'b1; two_strob = 1'b1;
    measure("long2", 18, 6, 6);

    // stop raised in the first STROB2 cycle lets the cycle finish
    found = 1'b0; prev = strob2;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (strob2 && !prev) begin found = 1'b1; break; end
      prev = strob2;
    end
    check("s2_reached", int'(found), 1);
    stop = 1'b1;
    c2 = 1; cg = 0; done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (seq_st == 3'd0) begin done = 1'b1; break; end
      c2 += int'(strob2); cg += int'(got);
    end
    check("stop_reach_gate", int'(done), 1);
    check("stop_s2_len", c2, 6);
    check("stop_got_len", cg, 5);
    check("stop_halted", int'(halted), 1);
    s = 0;
    repeat (20) begin tick(); s += int'(strob1); end
    check("stop_hold", s, 0);

    // step edge while mode=0 must not be remembered
    step = 1'b1;
    repeat (4) tick();
    step = 1'b0;
    repeat (4) tick();
    mode = 1'b1; stop = 1'b0;
    s = 0;
    repeat (15) begin tick(); s += int'(strob1); end
    check("step_discard", s, 0);
    check("discard_halted", int'(halted), 1);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
